booth_datapath: RTL and testbench

Datapath stage of the signed radix-2 Booth multiplier. It sits directly downstream of the Booth controller and consumes its control vector: load_Acc, load_Q, load_M, add_sub_en, sel_Mux, c_enable and i_clr_q. It holds the M, ACC, Q and Q_-1 registers, the adder/subtractor and the iteration counter. It returns Q[0], Q_-1 and the done flag to the controller, and presents the 2*WIDTH-bit signed product.

---
 rtl/booth_datapath_if.sv | 37 +++
 rtl/booth_datapath.sv | 85 ++++++++
 tb/tb_booth_datapath.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/booth_datapath_if.sv
// booth_datapath_if: operand, control and result bundle between the Booth controller and datapath.
// Carries o_proto_err only when BOOTH_PROTO_CHK_EN is defined.
interface booth_datapath_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0]   i_multiplicand;
    logic [WIDTH-1:0]   i_multiplier;
    logic               load_Acc;
    logic               load_Q;
    logic               load_M;
    logic               add_sub_en;
    logic               sel_Mux;
    logic               c_enable;
    logic               i_clr_q;
    logic               Q;
    logic               Q_n;
    logic               o_assert_done;
    logic [2*WIDTH-1:0] o_product;
    logic               o_valid;
`ifdef BOOTH_PROTO_CHK_EN
    logic               o_proto_err;
`endif
    modport master (
`ifdef BOOTH_PROTO_CHK_EN
        input  o_proto_err,
`endif
        output i_multiplicand, i_multiplier, load_Acc, load_Q, load_M,
               add_sub_en, sel_Mux, c_enable, i_clr_q,
        input  Q, Q_n, o_assert_done, o_product, o_valid
    );
    modport slave (
`ifdef BOOTH_PROTO_CHK_EN
        output o_proto_err,
`endif
        input  i_multiplicand, i_multiplier, load_Acc, load_Q, load_M,
               add_sub_en, sel_Mux, c_enable, i_clr_q,
        output Q, Q_n, o_assert_done, o_product, o_valid
    );
endinterface

// File: rtl/booth_datapath.sv
// booth_datapath: M/ACC/Q/Q_-1 registers, adder/subtractor and counter of a radix-2 Booth multiplier.
// Optional sticky protocol checker enabled by BOOTH_PROTO_CHK_EN.
module booth_datapath #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          i_clk,
    input logic          i_rst_n,
    booth_datapath_if.slave bus
);
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic               q_n;
    logic [CNT_W-1:0]   count;
    logic               busy;
    logic [2*WIDTH-1:0] product;
    logic               valid;
    logic               acc_en;
    logic               cnt_zero;
    logic               load;
    logic [WIDTH:0]     sum_x;
    logic [WIDTH-1:0]   a_nxt;
    logic               a_sign;

    assign acc_en   = bus.load_Acc & bus.sel_Mux;
    assign cnt_zero = (count == '0);
    assign load     = bus.load_Q | bus.load_M;
    // One guard bit keeps the true sign of the sum, so M = -2^(W-1) shifts in the right sign
    assign sum_x  = {acc[WIDTH-1], acc}
                  + (bus.add_sub_en ? ~{m[WIDTH-1], m} : {m[WIDTH-1], m})
                  + (WIDTH+1)'(bus.c_enable);
    assign a_nxt  = acc_en ? sum_x[WIDTH-1:0] : acc;
    assign a_sign = acc_en ? sum_x[WIDTH] : acc[WIDTH-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_n     <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            product <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bus.load_M) m <= bus.i_multiplicand;
            if (bus.load_Q) begin
                q     <= bus.i_multiplier;
                acc   <= '0;
                q_n   <= 1'b0;
                count <= CNT_W'(WIDTH);
                busy  <= 1'b1;
            end else if (!load && bus.i_clr_q && busy) begin
                product <= {acc, q};
                busy    <= 1'b0;
                valid   <= 1'b1;
            end else if (!load && !bus.i_clr_q && busy && !cnt_zero) begin
                {acc, q, q_n} <= {a_sign, a_nxt, q};
                count         <= count - 1'b1;
            end
        end
    end

    assign bus.Q             = q[0];
    assign bus.Q_n           = q_n;
    assign bus.o_assert_done = busy & cnt_zero;
    assign bus.o_product     = product;
    assign bus.o_valid       = valid;

`ifdef BOOTH_PROTO_CHK_EN
    logic proto_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            proto_err <= 1'b0;
        else if ((bus.load_Q & busy) | (bus.i_clr_q & ~busy) | (acc_en & (~busy | cnt_zero))
                 | (acc_en & (bus.add_sub_en != bus.c_enable)))
            proto_err <= 1'b1;
    end

    assign bus.o_proto_err = proto_err;
`endif
endmodule

// File: tb/tb_booth_datapath.sv
// tb_booth_datapath: directed Booth sequences with a product scoreboard and decoupled monitor.
module tb_booth_datapath;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [2*W-1:0] sb[$];

    always #5 clk = ~clk;

    booth_datapath_if #(.WIDTH(W)) bus ();

    booth_datapath #(.WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_ctrl();
        bus.load_Q = 0; bus.load_M = 0; bus.load_Acc = 0; bus.sel_Mux = 0;
        bus.add_sub_en = 0; bus.c_enable = 0; bus.i_clr_q = 0;
    endtask

    task automatic load(input logic [W-1:0] mv, input logic [W-1:0] qv);
        @(negedge clk);
        idle_ctrl();
        bus.i_multiplicand = mv;
        bus.i_multiplier   = qv;
        bus.load_M = 1;
        bus.load_Q = 1;
    endtask

    // Controller role: pick add/subtract/none from {Q0, Q_-1} for the coming shift
    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("done_early", bus.o_assert_done, 0);
            idle_ctrl();
            if ({bus.Q, bus.Q_n} == 2'b01) begin
                bus.load_Acc = 1; bus.sel_Mux = 1;
            end else if ({bus.Q, bus.Q_n} == 2'b10) begin
                bus.load_Acc = 1; bus.sel_Mux = 1; bus.add_sub_en = 1; bus.c_enable = 1;
            end
        end
    endtask

    task automatic finish(input logic [2*W-1:0] exp);
        @(negedge clk);
        chk("done_after_shifts", bus.o_assert_done, 1);
        idle_ctrl();
        bus.i_clr_q = 1;
        sb.push_back(exp);
        @(negedge clk);
        chk("done_after_capture", bus.o_assert_done, 0);
        idle_ctrl();
    endtask

    task automatic op(input logic [W-1:0] mv, input logic [W-1:0] qv, input logic [2*W-1:0] exp);
        load(mv, qv);
        shifts(W);
        finish(exp);
    endtask

    always @(negedge clk) begin
        if (bus.o_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL valid_unexpected actual=%0h required=no_pulse", bus.o_product);
            end else begin
                automatic logic [2*W-1:0] e = sb.pop_front();
                if (bus.o_product !== e) begin
                    failures++;
                    $display("FAIL product actual=%0h required=%0h", bus.o_product, e);
                end
            end
        end
    end

    initial begin
        rst_n = 0;
        bus.i_multiplicand = '0;
        bus.i_multiplier = '0;
        idle_ctrl();
        repeat (2) @(negedge clk);
        chk("rst_product", bus.o_product, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_done", bus.o_assert_done, 0);
        chk("rst_q", {bus.Q, bus.Q_n}, 0);
`ifdef BOOTH_PROTO_CHK_EN
        chk("rst_perr", bus.o_proto_err, 0);
`endif
        rst_n = 1;

        op(4'h3, 4'hE, 8'hFA);
        op(4'h8, 4'h8, 8'h40);
`ifdef BOOTH_PROTO_CHK_EN
        chk("perr_clean", bus.o_proto_err, 0);
`endif
        op(4'h7, 4'h7, 8'h31);
        op(4'h8, 4'h7, 8'hC8);
        op(4'h0, 4'hF, 8'h00);

        load(4'h3, 4'h3);
        shifts(2);
        @(negedge clk);
        idle_ctrl();
        rst_n = 0;
        @(negedge clk);
        chk("abort_product", bus.o_product, 0);
        chk("abort_valid", bus.o_valid, 0);
        chk("abort_done", bus.o_assert_done, 0);
        chk("abort_q", {bus.Q, bus.Q_n}, 0);
        rst_n = 1;

        op(4'h5, 4'hD, 8'hF1);

        @(negedge clk);
        bus.i_clr_q = 1;
        @(negedge clk);
        bus.i_clr_q = 0;
        @(negedge clk);
        chk("idle_clr_product", bus.o_product, 8'hF1);
        chk("idle_clr_done", bus.o_assert_done, 0);
`ifdef BOOTH_PROTO_CHK_EN
        chk("perr_set", bus.o_proto_err, 1);
        repeat (3) @(negedge clk);
        chk("perr_held", bus.o_proto_err, 1);
`endif
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
`ifdef BOOTH_PROTO_CHK_EN
        chk("perr_cleared", bus.o_proto_err, 0);
`endif

        load(4'h3, 4'h3);
        shifts(2);
        load(4'h6, 4'h2);
        shifts(W);
        finish(8'h0C);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
